// File: rtl/dtpu_csr_host_if.sv
// AXI4-Lite register bank for the DTPU host interface: start/done handshake,
// precision byte and interrupt toward the PS, plus the control unit's CSR read port.
module dtpu_csr_host_if #(
  parameter int         DATA_WIDTH_CSR   = 8,
  parameter int         ADDRESS_SIZE_CSR = 32,
  parameter int         AXI_ADDR_WIDTH   = 6,
  parameter int         AXI_DATA_WIDTH   = 32,
  parameter logic [7:0] PRECISION_RESET  = 8'h00
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_awaddr,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_wstrb,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  output logic [1:0]                    s_bresp,
  output logic                          s_bvalid,
  input  logic                          s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_araddr,
  input  logic                          s_arvalid,
  output logic                          s_arready,
  output logic [AXI_DATA_WIDTH-1:0]     s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rvalid,
  input  logic                          s_rready,
  input  logic                          csr_ce,
  input  logic                          csr_we,
  input  logic [ADDRESS_SIZE_CSR-1:0]   csr_address,
  input  logic                          csr_reset,
  output logic [DATA_WIDTH_CSR-1:0]     csr_dout,
  output logic                          cs_start,
  output logic                          cs_continue,
  input  logic                          cs_ready,
  input  logic                          cs_done,
  input  logic                          cs_idle,
  output logic                          irq
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         WIDX        = AXI_ADDR_WIDTH - 2;
  localparam logic [WIDX-1:0] IDX_CTRL = WIDX'(4'd0);
  localparam logic [WIDX-1:0] IDX_GIE  = WIDX'(4'd1);
  localparam logic [WIDX-1:0] IDX_PREC = WIDX'(4'd4);
  localparam logic [WIDX-1:0] IDX_DCNT = WIDX'(4'd5);

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  w_state_t w_state_r, w_state_nxt_s;
  r_state_t r_state_r, r_state_nxt_s;
  logic     w_open_r, arready_r;
  logic     w_hs_s, r_hs_s;

  logic [1:0]                bresp_r, rresp_r;
  logic [AXI_DATA_WIDTH-1:0] rdata_r, rd_data_s;
  logic                      rd_ok_s;
  logic [DATA_WIDTH_CSR-1:0] csr_dout_r;

  logic        ap_start_r, ap_done_r, ap_idle_r, ap_ready_r, auto_restart_r, cont_r;
  logic        gie_r, irq_r;
  logic [15:0] done_cnt_r;
  logic [7:0]  prec_r;

  logic        ap_start_nxt_s, ap_done_nxt_s, ap_ready_nxt_s, auto_restart_nxt_s, cont_nxt_s;
  logic        gie_nxt_s;
  logic [15:0] done_cnt_nxt_s;
  logic [7:0]  prec_nxt_s;
  logic [7:0]  ctrl_byte_s;

  logic [WIDX-1:0] waddr_idx_s, raddr_idx_s;
  logic wr_ctrl_s, wr_gie_s, wr_prec_s, wr_dcnt_s, w_mapped_s, rd_ctrl_s;
  logic unused_s;

  assign waddr_idx_s = s_awaddr[AXI_ADDR_WIDTH-1:2];
  assign raddr_idx_s = s_araddr[AXI_ADDR_WIDTH-1:2];
  assign unused_s    = ^{csr_we, csr_address, s_awaddr, s_araddr, s_wdata, s_wstrb};

  // Write channel next state; address and data are only taken together
  always_comb begin
    w_state_nxt_s = w_state_r;
    w_hs_s        = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        w_hs_s = w_open_r & s_awvalid & s_wvalid;
        if (w_hs_s) w_state_nxt_s = W_RESP;
        else        w_state_nxt_s = W_IDLE;
      end
      W_RESP: begin
        if (s_bready) w_state_nxt_s = W_IDLE;
        else          w_state_nxt_s = W_RESP;
      end
      default: w_state_nxt_s = W_IDLE;
    endcase
  end

  // Read channel next state
  always_comb begin
    r_state_nxt_s = r_state_r;
    r_hs_s        = 1'b0;
    case (r_state_r)
      R_IDLE: begin
        r_hs_s = arready_r & s_arvalid;
        if (r_hs_s) r_state_nxt_s = R_DATA;
        else        r_state_nxt_s = R_IDLE;
      end
      R_DATA: begin
        if (s_rready) r_state_nxt_s = R_IDLE;
        else          r_state_nxt_s = R_DATA;
      end
      default: r_state_nxt_s = R_IDLE;
    endcase
  end

  assign wr_ctrl_s  = w_hs_s && (waddr_idx_s == IDX_CTRL);
  assign wr_gie_s   = w_hs_s && (waddr_idx_s == IDX_GIE);
  assign wr_prec_s  = w_hs_s && (waddr_idx_s == IDX_PREC);
  assign wr_dcnt_s  = w_hs_s && (waddr_idx_s == IDX_DCNT);
  assign w_mapped_s = (waddr_idx_s == IDX_CTRL) || (waddr_idx_s == IDX_GIE) ||
                      (waddr_idx_s == IDX_PREC) || (waddr_idx_s == IDX_DCNT);
  assign rd_ctrl_s  = r_hs_s && (raddr_idx_s == IDX_CTRL);
  assign ctrl_byte_s = {auto_restart_r, 3'b000, ap_ready_r, ap_idle_r, ap_done_r, ap_start_r};

  // Read data mux over current (pre-write) register values
  always_comb begin
    rd_data_s = {AXI_DATA_WIDTH{1'b0}};
    rd_ok_s   = 1'b1;
    case (raddr_idx_s)
      IDX_CTRL: rd_data_s = AXI_DATA_WIDTH'(ctrl_byte_s);
      IDX_GIE:  rd_data_s = AXI_DATA_WIDTH'(gie_r);
      IDX_PREC: rd_data_s = AXI_DATA_WIDTH'(prec_r);
      IDX_DCNT: rd_data_s = AXI_DATA_WIDTH'(done_cnt_r);
      default: begin
        rd_data_s = {AXI_DATA_WIDTH{1'b0}};
        rd_ok_s   = 1'b0;
      end
    endcase
  end

  // Control/status next values; hardware set events beat clear-on-read
  always_comb begin
    if (wr_ctrl_s && s_wdata[0])         ap_start_nxt_s = 1'b1;
    else if (cs_ready && !auto_restart_r) ap_start_nxt_s = 1'b0;
    else                                 ap_start_nxt_s = ap_start_r;

    if (cs_done)        ap_done_nxt_s = 1'b1;
    else if (rd_ctrl_s) ap_done_nxt_s = 1'b0;
    else                ap_done_nxt_s = ap_done_r;

    if (cs_ready)       ap_ready_nxt_s = 1'b1;
    else if (rd_ctrl_s) ap_ready_nxt_s = 1'b0;
    else                ap_ready_nxt_s = ap_ready_r;

    if (wr_ctrl_s) auto_restart_nxt_s = s_wdata[7];
    else           auto_restart_nxt_s = auto_restart_r;

    cont_nxt_s = wr_ctrl_s & s_wdata[4];

    if (wr_gie_s) gie_nxt_s = s_wdata[0];
    else          gie_nxt_s = gie_r;

    if (wr_dcnt_s)                             done_cnt_nxt_s = 16'h0000;
    else if (cs_done && (done_cnt_r != 16'hFFFF)) done_cnt_nxt_s = done_cnt_r + 16'd1;
    else                                       done_cnt_nxt_s = done_cnt_r;

    // Precision is frozen while the CU may be consuming it
    if (csr_reset)                                            prec_nxt_s = PRECISION_RESET;
    else if (wr_prec_s && s_wstrb[0] && !ap_start_r && ap_idle_r) prec_nxt_s = s_wdata[7:0];
    else                                                      prec_nxt_s = prec_r;
  end

  // Channel state, response and register-bank flops
  always_ff @(posedge clk) begin
    if (!reset) begin
      w_state_r      <= W_IDLE;
      r_state_r      <= R_IDLE;
      w_open_r       <= 1'b0;
      arready_r      <= 1'b0;
      bresp_r        <= 2'b00;
      rresp_r        <= 2'b00;
      rdata_r        <= {AXI_DATA_WIDTH{1'b0}};
      ap_start_r     <= 1'b0;
      ap_done_r      <= 1'b0;
      ap_idle_r      <= 1'b0;
      ap_ready_r     <= 1'b0;
      auto_restart_r <= 1'b0;
      cont_r         <= 1'b0;
      gie_r          <= 1'b0;
      irq_r          <= 1'b0;
      done_cnt_r     <= 16'h0000;
      prec_r         <= PRECISION_RESET;
    end else begin
      w_state_r      <= w_state_nxt_s;
      r_state_r      <= r_state_nxt_s;
      w_open_r       <= (w_state_nxt_s == W_IDLE);
      arready_r      <= (r_state_nxt_s == R_IDLE);
      if (w_hs_s) bresp_r <= w_mapped_s ? RESP_OKAY : RESP_SLVERR;
      else        bresp_r <= bresp_r;
      if (r_hs_s) begin
        rdata_r <= rd_data_s;
        rresp_r <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
      end else begin
        rdata_r <= rdata_r;
        rresp_r <= rresp_r;
      end
      ap_start_r     <= ap_start_nxt_s;
      ap_done_r      <= ap_done_nxt_s;
      ap_idle_r      <= cs_idle;
      ap_ready_r     <= ap_ready_nxt_s;
      auto_restart_r <= auto_restart_nxt_s;
      cont_r         <= cont_nxt_s;
      gie_r          <= gie_nxt_s;
      irq_r          <= gie_nxt_s & ap_done_nxt_s;
      done_cnt_r     <= done_cnt_nxt_s;
      prec_r         <= prec_nxt_s;
    end
  end

  // Control-unit CSR read port, one-cycle latency, holds when not enabled
  always_ff @(posedge clk) begin
    if (!reset) begin
      csr_dout_r <= {DATA_WIDTH_CSR{1'b0}};
    end else if (csr_ce) begin
      case (csr_address[3:0])
        4'h0:    csr_dout_r <= DATA_WIDTH_CSR'(prec_r);
        4'h1:    csr_dout_r <= DATA_WIDTH_CSR'(ctrl_byte_s);
        default: csr_dout_r <= {DATA_WIDTH_CSR{1'b0}};
      endcase
    end else begin
      csr_dout_r <= csr_dout_r;
    end
  end

  assign s_awready   = w_hs_s;
  assign s_wready    = w_hs_s;
  assign s_bvalid    = (w_state_r == W_RESP);
  assign s_bresp     = bresp_r;
  assign s_arready   = arready_r;
  assign s_rvalid    = (r_state_r == R_DATA);
  assign s_rdata     = rdata_r;
  assign s_rresp     = rresp_r;
  assign csr_dout    = csr_dout_r;
  assign cs_start    = ap_start_r;
  assign cs_continue = cont_r;
  assign irq         = irq_r;

endmodule

// File: tb/tb_dtpu_csr_host_if.sv
// Directed self-checking bench for dtpu_csr_host_if; expected values are hand-computed.
module tb_dtpu_csr_host_if;

  logic        clk, reset;
  logic [5:0]  s_awaddr, s_araddr;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        csr_ce, csr_we, csr_reset;
  logic [31:0] csr_address;
  logic [7:0]  csr_dout;
  logic        cs_start, cs_continue, cs_ready, cs_done, cs_idle, irq;

  int   vec_cnt = 0;
  int   miss_cnt = 0;
  logic cont_seen, cont_after;

  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  dtpu_csr_host_if dut (
    .clk(clk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .csr_ce(csr_ce), .csr_we(csr_we), .csr_address(csr_address), .csr_reset(csr_reset),
    .csr_dout(csr_dout), .cs_start(cs_start), .cs_continue(cs_continue),
    .cs_ready(cs_ready), .cs_done(cs_done), .cs_idle(cs_idle), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] strb,
                        input logic [1:0] exp_resp, input string tag);
    int n;
    @(negedge clk);
    s_awaddr = a; s_wdata = d; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    #1; n = 0;
    while (!s_awready && n < 20) begin @(negedge clk); #1; n++; end
    check_vec({tag, "_awaccept"}, {31'd0, s_awready}, 32'd1);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    cont_seen = cs_continue;
    n = 0;
    while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
    check_vec({tag, "_bvalid"}, {31'd0, s_bvalid}, 32'd1);
    check_vec({tag, "_bresp"}, {30'd0, s_bresp}, {30'd0, exp_resp});
    @(negedge clk);
    cont_after = cs_continue;
  endtask

  task automatic axi_rd(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    @(negedge clk);
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
    #1; n = 0;
    while (!s_arready && n < 20) begin @(negedge clk); #1; n++; end
    check_vec("araccept", {31'd0, s_arready}, 32'd1);
    @(negedge clk);
    s_arvalid = 1'b0;
    n = 0;
    while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
    check_vec("rvalid", {31'd0, s_rvalid}, 32'd1);
    d = s_rdata; r = s_rresp;
    @(negedge clk);
  endtask

  task automatic rd_chk(input logic [5:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                        input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    axi_rd(a, d, r);
    check_vec({tag, "_rdata"}, d, exp_d);
    check_vec({tag, "_rresp"}, {30'd0, r}, {30'd0, exp_r});
  endtask

  task automatic pulse_ready();
    @(negedge clk); cs_ready = 1'b1;
    @(negedge clk); cs_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    s_awaddr = 6'h00; s_awvalid = 1'b0; s_wdata = 32'h0; s_wstrb = 4'hF; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = 6'h00; s_arvalid = 1'b0; s_rready = 1'b0;
    csr_ce = 1'b0; csr_we = 1'b0; csr_address = 32'h0; csr_reset = 1'b0;
    cs_ready = 1'b0; cs_done = 1'b0; cs_idle = 1'b1;
    cont_seen = 1'b0; cont_after = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("rst_arready", {31'd0, s_arready}, 32'd0);
    check_vec("rst_bvalid",  {31'd0, s_bvalid},  32'd0);
    check_vec("rst_rvalid",  {31'd0, s_rvalid},  32'd0);
    check_vec("rst_rdata",   s_rdata,            32'd0);
    check_vec("rst_csrdout", {24'd0, csr_dout},  32'd0);
    check_vec("rst_start",   {31'd0, cs_start},  32'd0);
    check_vec("rst_cont",    {31'd0, cs_continue}, 32'd0);
    check_vec("rst_irq",     {31'd0, irq},       32'd0);
    reset = 1'b1;
    @(negedge clk);
    rd_chk(6'h10, 32'h0, OKAY, "rst_prec");
    rd_chk(6'h14, 32'h0, OKAY, "rst_dcnt");

    // precision write and CU read port
    axi_wr(6'h10, 32'h0000_000A, 4'hF, OKAY, "wr_prec");
    @(negedge clk); csr_ce = 1'b1; csr_address = 32'h0;
    @(negedge clk); csr_ce = 1'b0; csr_address = 32'h1;
    check_vec("cu_prec", {24'd0, csr_dout}, 32'h0A);
    @(negedge clk);
    check_vec("cu_hold", {24'd0, csr_dout}, 32'h0A);
    csr_ce = 1'b1;
    @(negedge clk); csr_ce = 1'b0;
    check_vec("cu_ctrl", {24'd0, csr_dout}, 32'h04);
    rd_chk(6'h10, 32'h0000_000A, OKAY, "rd_prec");
    rd_chk(6'h13, 32'h0000_000A, OKAY, "rd_prec_unaligned");

    // start / ready handshake
    axi_wr(6'h00, 32'h01, 4'hF, OKAY, "start");
    check_vec("start_hi", {31'd0, cs_start}, 32'd1);
    pulse_ready();
    check_vec("start_clr", {31'd0, cs_start}, 32'd0);
    rd_chk(6'h00, 32'h0C, OKAY, "ctrl_ready1");
    rd_chk(6'h00, 32'h04, OKAY, "ctrl_ready2");
    axi_wr(6'h00, 32'h01, 4'hF, OKAY, "start2");
    axi_wr(6'h00, 32'h00, 4'hF, OKAY, "wr0");
    check_vec("wr0_noeffect", {31'd0, cs_start}, 32'd1);
    pulse_ready();
    rd_chk(6'h00, 32'h0C, OKAY, "ctrl_ready3");
    axi_wr(6'h00, 32'h10, 4'hF, OKAY, "cont");
    check_vec("cont_pulse", {31'd0, cont_seen}, 32'd1);
    check_vec("cont_clear", {31'd0, cont_after}, 32'd0);
    check_vec("cont_nostart", {31'd0, cs_start}, 32'd0);

    // done, irq, clear-on-read
    axi_wr(6'h04, 32'h01, 4'hF, OKAY, "gie");
    rd_chk(6'h04, 32'h01, OKAY, "rd_gie");
    @(negedge clk); cs_done = 1'b1;
    @(negedge clk); cs_done = 1'b0;
    check_vec("irq_set", {31'd0, irq}, 32'd1);
    rd_chk(6'h14, 32'd1, OKAY, "dcnt1");
    rd_chk(6'h00, 32'h06, OKAY, "ctrl_done");
    check_vec("irq_drop", {31'd0, irq}, 32'd0);
    @(negedge clk);
    s_araddr = 6'h00; s_arvalid = 1'b1; s_rready = 1'b1; cs_done = 1'b1;
    @(negedge clk);
    s_arvalid = 1'b0; cs_done = 1'b0;
    check_vec("coin_rvalid", {31'd0, s_rvalid}, 32'd1);
    check_vec("coin_rdata", s_rdata, 32'h04);
    check_vec("coin_irq", {31'd0, irq}, 32'd1);
    rd_chk(6'h00, 32'h06, OKAY, "coin_done_kept");
    check_vec("coin_irq_drop", {31'd0, irq}, 32'd0);
    rd_chk(6'h14, 32'd2, OKAY, "dcnt2");

    // auto restart and precision lock
    axi_wr(6'h00, 32'h81, 4'hF, OKAY, "autostart");
    for (int i = 0; i < 3; i++) begin
      pulse_ready();
      check_vec("auto_start_hold", {31'd0, cs_start}, 32'd1);
    end
    rd_chk(6'h00, 32'h8D, OKAY, "ctrl_auto");
    axi_wr(6'h10, 32'h05, 4'hF, OKAY, "prec_locked");
    rd_chk(6'h10, 32'h0A, OKAY, "prec_unchanged");
    axi_wr(6'h00, 32'h00, 4'hF, OKAY, "auto_off");
    pulse_ready();
    check_vec("auto_off_clr", {31'd0, cs_start}, 32'd0);
    rd_chk(6'h00, 32'h0C, OKAY, "ctrl_after_auto");
    cs_idle = 1'b0;
    repeat (2) @(negedge clk);
    axi_wr(6'h10, 32'h22, 4'hF, OKAY, "prec_busy");
    rd_chk(6'h10, 32'h0A, OKAY, "prec_busy_unch");
    rd_chk(6'h00, 32'h00, OKAY, "ctrl_notidle");
    cs_idle = 1'b1;
    repeat (2) @(negedge clk);
    axi_wr(6'h10, 32'h77, 4'hE, OKAY, "prec_strb");
    rd_chk(6'h10, 32'h0A, OKAY, "prec_strb_unch");

    // unmapped addresses and write-response backpressure
    axi_wr(6'h3C, 32'hFF, 4'hF, SLVERR, "wr_unmapped");
    rd_chk(6'h3C, 32'h0, SLVERR, "rd_unmapped");
    rd_chk(6'h08, 32'h0, SLVERR, "rd_unmapped08");
    @(negedge clk);
    s_awaddr = 6'h04; s_wdata = 32'h0; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
    #1;
    check_vec("bp_accept", {31'd0, s_awready}, 32'd1);
    @(negedge clk);
    s_wdata = 32'h1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_vec("bp_bvalid", {31'd0, s_bvalid}, 32'd1);
      check_vec("bp_noaccept", {31'd0, s_awready}, 32'd0);
      @(negedge clk);
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    @(negedge clk);
    check_vec("bp_release", {31'd0, s_bvalid}, 32'd0);
    rd_chk(6'h04, 32'h0, OKAY, "bp_gie");

    // DONE_CNT clear priority and saturation
    @(negedge clk);
    s_awaddr = 6'h14; s_wdata = 32'h0; s_awvalid = 1'b1; s_wvalid = 1'b1; cs_done = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; cs_done = 1'b0;
    check_vec("clrwin_bvalid", {31'd0, s_bvalid}, 32'd1);
    check_vec("clrwin_bresp", {30'd0, s_bresp}, 32'd0);
    @(negedge clk);
    rd_chk(6'h14, 32'h0, OKAY, "clrwin_dcnt");
    cs_done = 1'b1;
    repeat (65540) @(negedge clk);
    cs_done = 1'b0;
    @(negedge clk);
    rd_chk(6'h14, 32'h0000_FFFF, OKAY, "dcnt_sat");
    @(negedge clk); cs_done = 1'b1;
    @(negedge clk); cs_done = 1'b0;
    rd_chk(6'h14, 32'h0000_FFFF, OKAY, "dcnt_sat_hold");
    axi_wr(6'h14, 32'h1234, 4'hF, OKAY, "dcnt_clr");
    rd_chk(6'h14, 32'h0, OKAY, "dcnt_cleared");

    // csr_reset priority
    axi_wr(6'h04, 32'h01, 4'hF, OKAY, "gie2");
    axi_wr(6'h10, 32'h33, 4'hF, OKAY, "prec33");
    rd_chk(6'h10, 32'h33, OKAY, "prec33_rd");
    @(negedge clk);
    s_awaddr = 6'h10; s_wdata = 32'h44; s_awvalid = 1'b1; s_wvalid = 1'b1; csr_reset = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; csr_reset = 1'b0;
    check_vec("csrrst_bresp", {30'd0, s_bresp}, 32'd0);
    @(negedge clk);
    rd_chk(6'h10, 32'h00, OKAY, "csrrst_prec");
    rd_chk(6'h04, 32'h01, OKAY, "csrrst_gie");

    // simultaneous write and read of the same register
    @(negedge clk);
    s_awaddr = 6'h10; s_wdata = 32'h55; s_awvalid = 1'b1; s_wvalid = 1'b1;
    s_araddr = 6'h10; s_arvalid = 1'b1; s_rready = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    check_vec("sim_rvalid", {31'd0, s_rvalid}, 32'd1);
    check_vec("sim_rdata_old", s_rdata, 32'h00);
    check_vec("sim_bvalid", {31'd0, s_bvalid}, 32'd1);
    @(negedge clk);
    rd_chk(6'h10, 32'h55, OKAY, "sim_after");

    // reset while a read response is pending
    @(negedge clk);
    s_araddr = 6'h00; s_arvalid = 1'b1; s_rready = 1'b0;
    @(negedge clk);
    s_arvalid = 1'b0;
    check_vec("rstmid_rvalid_pre", {31'd0, s_rvalid}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check_vec("rstmid_rvalid", {31'd0, s_rvalid}, 32'd0);
    check_vec("rstmid_arready", {31'd0, s_arready}, 32'd0);
    check_vec("rstmid_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1; s_rready = 1'b1;
    repeat (2) @(negedge clk);
    rd_chk(6'h04, 32'h0, OKAY, "rstmid_gie");
    rd_chk(6'h10, 32'h0, OKAY, "rstmid_prec");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/dtpu_csr_host_if.md
Name: dtpu_csr_host_if

Overview:
- AXI4-Lite responder and register bank on the PS side of the DTPU.
- Host-side: holds the start/done/idle/ready handshake and the arithmetic-precision byte, and drives cs_start/cs_continue toward the control unit.
- Control-unit side: serves the control unit's CSR read port (csr_ce/csr_address → csr_dout) with 1-cycle latency.
- Sits between the PS interconnect and control_unit.

Parameters:
- DATA_WIDTH_CSR, 8, width of the CU read port csr_dout.
- ADDRESS_SIZE_CSR, 32, width of the CU address csr_address.
- AXI_ADDR_WIDTH, 6, AXI-Lite byte address width.
- AXI_DATA_WIDTH, 32, AXI-Lite data width.
- PRECISION_RESET, 8'h00, reset value of the PRECISION register.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- s_awaddr  in  AXI_ADDR_WIDTH  write address
- s_awvalid / s_awready  in/out  1  write-address handshake
- s_wdata  in  AXI_DATA_WIDTH  write data
- s_wstrb  in  AXI_DATA_WIDTH/8  byte strobes
- s_wvalid / s_wready  in/out  1  write-data handshake
- s_bresp  out  2  write response
- s_bvalid / s_bready  out/in  1  write-response handshake
- s_araddr  in  AXI_ADDR_WIDTH  read address
- s_arvalid / s_arready  in/out  1  read-address handshake
- s_rdata  out  AXI_DATA_WIDTH  read data
- s_rresp  out  2  read response
- s_rvalid / s_rready  out/in  1  read-data handshake
- csr_ce  in  1  CU read enable
- csr_we  in  1  CU write enable; ignored, no CU write path
- csr_address  in  ADDRESS_SIZE_CSR  CU read address
- csr_reset  in  1  CU soft reset of PRECISION
- csr_dout  out  DATA_WIDTH_CSR  CU read data
- cs_start  out  1  start level to CU
- cs_continue  out  1  one-cycle continue pulse
- cs_ready  in  1  CU accepted start (pulse)
- cs_done  in  1  CU finished (pulse)
- cs_idle  in  1  CU idle
- irq  out  1  interrupt, level

Behaviour:

Reset:
- All ready/valid outputs are 0; bresp/rresp/rdata/csr_dout are 0.
- cs_start, cs_continue and irq are 0.
- CTRL and GIE are 0; DONE_CNT is 0; PRECISION = PRECISION_RESET.
- Reset mid-transaction drops the transaction; no response is issued.

Register map (byte address, word-aligned; addr[1:0] ignored):
- 0x00 CTRL:
  - b0 ap_start (W1S; hardware-cleared)
  - b1 ap_done (RO, clear-on-read)
  - b2 ap_idle (RO)
  - b3 ap_ready (RO, clear-on-read)
  - b4 continue (WO, self-clearing)
  - b7 auto_restart (RW)
- 0x04 GIE: b0 RW.
- 0x10 PRECISION: [7:0] RW, byte-lane 0 strobe only.
- 0x14 DONE_CNT: [15:0] RO; any write clears it.
- Any other address: writes ignored, reads return 0, resp = SLVERR (2'b10). Mapped accesses return OKAY.

Write channel FSM (W_IDLE → W_RESP → W_IDLE):
- In W_IDLE, s_awready = s_wready = 1 only when s_awvalid && s_wvalid; both are accepted in the same cycle.
- The register update happens in the acceptance cycle; s_bvalid is asserted on the next cycle.
- s_bvalid holds until s_bready; no new write is accepted while bvalid is high.

Read channel FSM (R_IDLE → R_DATA → R_IDLE):
- s_arready = 1 in R_IDLE.
- On acceptance, rdata is registered; s_rvalid is asserted on the next cycle and holds until s_rready.
- Clear-on-read side effects (ap_done, ap_ready) take effect at AR acceptance.

Simultaneous write and read:
- Both are serviced in the same cycle.
- The read returns pre-write values.

Control semantics:
- cs_start = ap_start.
- ap_start clears on cs_ready when auto_restart = 0; it stays 1 when auto_restart = 1.
- Writing 0 to b0 has no effect.
- ap_ready sets on cs_ready.
- ap_done sets on cs_done. If set and clear-on-read coincide, set wins.
- ap_idle is cs_idle registered (1-cycle delay).
- cs_continue pulses exactly 1 cycle after a write with b4 = 1.
- irq = GIE & ap_done.
- DONE_CNT increments on each cs_done and saturates at 16'hFFFF. Hardware increment and AXI clear in the same cycle: clear wins, result is 0.

PRECISION lock:
- Writes to PRECISION are ignored while ap_start = 1 or ap_idle = 0; the response is still OKAY.

CU read port:
- When csr_ce = 1, csr_dout is registered on the next cycle:
  - csr_address[3:0] = 0x0 → PRECISION
  - 0x1 → CTRL[7:0]
  - else → 0
- When csr_ce = 0, csr_dout holds its previous value.

csr_reset = 1:
- PRECISION ← PRECISION_RESET on the next edge.
- Priority over a same-cycle AXI write to PRECISION.
- Does not affect CTRL, GIE or DONE_CNT.

Test Plan:
- Write 0x10 = 0x0A with cs_idle = 1; then CU reads with csr_ce = 1, addr 0 → csr_dout = 8'h0A one cycle later; AXI read of 0x10 → 0x0000000A, OKAY.
- Write CTRL = 0x01 → cs_start = 1. Pulse cs_ready → cs_start = 0 next cycle; CTRL read shows b3 = 1; a second read shows b3 = 0.
- Set GIE = 1 and pulse cs_done → irq = 1, DONE_CNT = 1. Read CTRL → b1 = 1 and irq drops; cs_done in the same cycle as the AR accept → ap_done stays 1.
- Set auto_restart (CTRL = 0x81) and pulse cs_ready 3× → cs_start stays 1. Write PRECISION = 0x05 while ap_start = 1 → value unchanged, bresp = OKAY.
- Write 0x3C → bresp = SLVERR; read 0x3C → 0, SLVERR. Hold s_bready = 0 for 5 cycles → bvalid held and the next AW/W is not accepted.
- Force DONE_CNT to 0xFFFF, pulse cs_done → stays 0xFFFF. Assert csr_reset together with an AXI write of PRECISION = 0x33 → PRECISION = PRECISION_RESET. Assert reset while rvalid = 1 → rvalid = 0 next cycle.
